code_seq_driver: RTL

Scripted initiator for the switch-driven code-sequencer protocol: it drives the lines A–E and the target's active-low reset through the full sequence, then checks that the 4-bit response code follows the required progression. Each run is started by a one-cycle `start` pulse with a 2-bit data selection. The run ends with a `done` pulse, or with `err` plus the failing phase. It sits on the board/test side, in place of hand-operated switches, and feeds the code sequencer's inputs directly.

---
 rtl/code_seq_pkg.sv | 83 ++++++++
 rtl/phase_timer.sv | 64 ++++++
 rtl/code_seq_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/code_seq_pkg.sv
// Shared state encoding, response codes and per-phase line drive for the
// code-sequencer initiator.
package code_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_ARM  = 3'd2,
    S_PA   = 3'd3,
    S_PB   = 3'd4,
    S_PE   = 3'd5,
    S_PNA  = 3'd6,
    S_FIN  = 3'd7
  } state_e;

  localparam logic [3:0] C_IDLE  = 4'hC;
  localparam logic [3:0] C_ARM   = 4'hB;
  localparam logic [3:0] C_A     = 4'hA;
  localparam logic [3:0] C_EVEN  = 4'hE;
  localparam logic [3:0] C_ODD   = 4'h0;
  localparam logic [3:0] C_FIN   = 4'hF;
  localparam logic [3:0] C_DBASE = 4'h2;

  typedef struct packed {
    logic tgt_rst_n;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
  } lines_t;

  function automatic logic [3:0] data_code(input logic [1:0] sel);
    return C_DBASE + {2'b00, sel};
  endfunction

  // Line levels held for the whole of a phase; IDLE/RST/FIN keep the target in reset.
  function automatic lines_t phase_drive(input state_e s, input logic [1:0] sel);
    lines_t l;
    l = '0;
    case (s)
      S_ARM: l.tgt_rst_n = 1'b1;
      S_PA: begin
        l.tgt_rst_n = 1'b1;
        l.a         = 1'b1;
      end
      S_PB: begin
        l.tgt_rst_n = 1'b1;
        l.a         = 1'b1;
        l.b         = 1'b1;
        l.c         = sel[0];
        l.d         = sel[1];
      end
      S_PE: begin
        l.tgt_rst_n = 1'b1;
        l.a         = 1'b1;
        l.c         = sel[0];
        l.d         = sel[1];
        l.e         = 1'b1;
      end
      S_PNA: begin
        l.tgt_rst_n = 1'b1;
        l.c         = sel[0];
        l.d         = sel[1];
        l.e         = 1'b1;
      end
      default: l = '0;
    endcase
    return l;
  endfunction

  function automatic state_e next_phase(input state_e s);
    case (s)
      S_RST:   return S_ARM;
      S_ARM:   return S_PA;
      S_PA:    return S_PB;
      S_PB:    return S_PE;
      S_PE:    return S_PNA;
      default: return S_FIN;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase hold counter (consecutive matches) and saturating wait counter;
// the wait counter exists only with CODE_SEQ_DRV_TIMEOUT_EN.
module phase_timer #(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic match,
  output logic advance,
  output logic expired
);

  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

  if (HOLD_CYC < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("phase_timer: HOLD_CYC must be >= 1 and TIMEOUT in 1..255");
  end

  logic [HW-1:0] hold_q, hold_d;

  // First match loads 1; a phase completes on the match seen with HOLD_CYC already counted.
  assign advance = match && (hold_q == HOLD_MAX);

  always_comb begin
    hold_d = hold_q;
    if (clear || !match) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

`ifdef CODE_SEQ_DRV_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic [7:0] wait_q;

  assign expired = (wait_q >= TO_LIM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q <= '0;
    end else if (clear) begin
      wait_q <= '0;
    end else if (wait_q != 8'hFF) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

endmodule

// File: rtl/code_seq_driver.sv
// Scripted initiator driving the code sequencer through RST..PNA and checking each response.
// Timeout/err reporting is built only with CODE_SEQ_DRV_TIMEOUT_EN.
module code_seq_driver
  import code_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [3:0] resp,
  output logic       tgt_rst_n,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_phase
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] sel_q;
  lines_t     lines_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] exp_code;
  logic       in_phase;
  logic       match;
  logic       clear;
  logic       advance;
  logic       expired;

  always_comb begin
    exp_code = C_IDLE;
    case (state_q)
      S_RST:   exp_code = C_IDLE;
      S_ARM:   exp_code = C_ARM;
      S_PA:    exp_code = C_A;
      S_PB:    exp_code = data_code(sel_q);
      S_PE:    exp_code = sel_q[0] ? C_ODD : C_EVEN;
      S_PNA:   exp_code = C_FIN;
      default: exp_code = C_IDLE;
    endcase
  end

  assign in_phase = (state_q != S_IDLE) && (state_q != S_FIN);
  assign match    = in_phase && (resp == exp_code);
  assign clear    = !in_phase || advance || expired;
  assign state_d  = next_phase(state_q);

  phase_timer #(
    .HOLD_CYC(HOLD_CYC),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .match  (match),
    .advance(advance),
    .expired(expired)
  );

`ifdef CODE_SEQ_DRV_TIMEOUT_EN
  logic       err_q;
  logic [2:0] err_phase_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      lines_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CODE_SEQ_DRV_TIMEOUT_EN
      err_q       <= 1'b0;
      err_phase_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CODE_SEQ_DRV_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RST;
            sel_q   <= sel;
            busy_q  <= 1'b1;
            lines_q <= phase_drive(S_RST, sel);
`ifdef CODE_SEQ_DRV_TIMEOUT_EN
            err_phase_q <= '0;
`endif
          end
        end
        // One dead cycle after done, so a start overlapping the done pulse is dropped.
        S_FIN: state_q <= S_IDLE;
        default: begin
          if (advance) begin
            state_q <= state_d;
            lines_q <= phase_drive(state_d, sel_q);
            if (state_d == S_FIN) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
`ifdef CODE_SEQ_DRV_TIMEOUT_EN
          else if (expired) begin
            state_q     <= S_IDLE;
            lines_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b1;
            err_phase_q <= state_q;
          end
`endif
        end
      endcase
    end
  end

  assign tgt_rst_n = lines_q.tgt_rst_n;
  assign a         = lines_q.a;
  assign b         = lines_q.b;
  assign c         = lines_q.c;
  assign d         = lines_q.d;
  assign e         = lines_q.e;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CODE_SEQ_DRV_TIMEOUT_EN
  assign err       = err_q;
  assign err_phase = err_phase_q;
`else
  assign err       = 1'b0;
  assign err_phase = '0;
`endif

endmodule
